// File: rtl/rob_pkg.sv
// ============================================================================
//  rob_pkg : shared types and defaults for the N-way reorder buffer
//  Revision: 1.0
// ============================================================================
`default_nettype none

package rob_pkg;

    localparam int ROB_SIZE_DEFAULT = 8;

    typedef struct packed {
        logic        valid;
        logic        complete;
        logic        exception;
        logic [4:0]  reg_idx;
        logic [31:0] reg_val;
    } ROB_ENTRY;

endpackage

`default_nettype wire

// File: rtl/rob_retire_select.sv
// ============================================================================
//  rob_retire_select : in-order retire mask (prefix-AND from head) and
//                      full-flush request for an exception at the head
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rob_retire_select #(
    parameter  int SIZE = 8,
    parameter  int W    = 3,
    localparam int TAGW = $clog2(SIZE)
) (
    input  logic [TAGW-1:0] head_i,
    input  logic            retire_en_i,
    input  logic [SIZE-1:0] valid_i,
    input  logic [SIZE-1:0] complete_i,
    input  logic [SIZE-1:0] exception_i,
    output logic [W-1:0]    retire_mask_o,
    output logic            clear_all_o
);

    always_comb begin
        logic            ok;
        logic [TAGW-1:0] idx;
        ok            = retire_en_i;
        idx           = head_i;
        retire_mask_o = '0;
        for (int k = 0; k < W; k++) begin
            idx              = head_i + TAGW'(k);
            ok               = ok & valid_i[idx] & complete_i[idx] & ~exception_i[idx];
            retire_mask_o[k] = ok;
        end
    end

    assign clear_all_o = retire_en_i & valid_i[head_i] & complete_i[head_i] & exception_i[head_i];

endmodule

`default_nettype wire

// File: rtl/rob_nway.sv
// ============================================================================
//  rob_nway : parametrised N-way reorder buffer with CDB bypass forwarding,
//             partial squash on mispredict and exception flush
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rob_nway
    import rob_pkg::*;
#(
    parameter  int SIZE = ROB_SIZE_DEFAULT,
    parameter  int W    = 3,
    parameter  int C    = 3,
    localparam int TAGW = $clog2(SIZE),
    localparam int FW   = $clog2(W + 1),
    localparam int CW   = $clog2(SIZE + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [FW-1:0]     dispatch_num,
    input  logic [W*5-1:0]    dest_reg_idx_in,
    input  logic [W*TAGW-1:0] map_table_rob_num,
    output logic [FW-1:0]     dispatch_free,
    output logic [W*TAGW-1:0] dispatch_tag,
    output logic [W*32-1:0]   dispatch_value_out,
    output logic [W-1:0]      dispatch_value_rdy,
    input  logic [C-1:0]      cdb_valid,
    input  logic [C*TAGW-1:0] CDB_rob_num,
    input  logic [C*32-1:0]   CDB_value,
    input  logic [C-1:0]      cdb_exception,
    input  logic              br_mispredict,
    input  logic [TAGW-1:0]   br_rob_tag,
    input  logic              retire_en,
    output logic [W-1:0]      retire_valid,
    output logic [W*5-1:0]    retire_R_out,
    output logic [W*32-1:0]   retire_V_out,
    output logic              clear_all,
    output logic [CW-1:0]     rob_count
);

    ROB_ENTRY        entry_q [SIZE];
    ROB_ENTRY        entry_d [SIZE];
    logic [TAGW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic [SIZE-1:0] valid_vec, complete_vec, exception_vec;
    logic [W-1:0]    ret_mask;
    logic [CW-1:0]   space, n_ret;
    logic [FW-1:0]   accepted;
    logic [TAGW-1:0] br_age;
    logic            br_hit;

    for (genvar i = 0; i < SIZE; i++) begin : g_flags
        assign valid_vec[i]     = entry_q[i].valid;
        assign complete_vec[i]  = entry_q[i].complete;
        assign exception_vec[i] = entry_q[i].exception;
    end

    rob_retire_select #(
        .SIZE (SIZE),
        .W    (W)
    ) u_retire_select (
        .head_i        (head_q),
        .retire_en_i   (retire_en),
        .valid_i       (valid_vec),
        .complete_i    (complete_vec),
        .exception_i   (exception_vec),
        .retire_mask_o (ret_mask),
        .clear_all_o   (clear_all)
    );

    // Free slots come from start-of-cycle occupancy only; same-cycle retires are not reused.
    assign space         = CW'(SIZE) - count_q;
    assign dispatch_free = (space >= CW'(W)) ? FW'(W) : FW'(space);
    assign accepted      = (dispatch_num < dispatch_free) ? dispatch_num : dispatch_free;
    assign rob_count     = count_q;

    assign br_age = br_rob_tag - head_q;
    assign br_hit = br_mispredict & entry_q[br_rob_tag].valid & ~clear_all;

    always_comb begin
        dispatch_tag = '0;
        for (int k = 0; k < W; k++) begin
            if (FW'(k) < accepted) begin
                dispatch_tag[k*TAGW +: TAGW] = tail_q + TAGW'(k);
            end
        end
    end

    // Lowest CDB channel wins the bypass: scan high to low so it is applied last.
    always_comb begin
        logic [TAGW-1:0] fwd_tag;
        fwd_tag            = '0;
        dispatch_value_out = '0;
        dispatch_value_rdy = '0;
        for (int k = 0; k < W; k++) begin
            fwd_tag                        = map_table_rob_num[k*TAGW +: TAGW];
            dispatch_value_out[k*32 +: 32] = entry_q[fwd_tag].reg_val;
            dispatch_value_rdy[k]          = entry_q[fwd_tag].valid & entry_q[fwd_tag].complete;
            for (int c = C - 1; c >= 0; c--) begin
                if (cdb_valid[c] && (CDB_rob_num[c*TAGW +: TAGW] == fwd_tag)) begin
                    dispatch_value_out[k*32 +: 32] = CDB_value[c*32 +: 32];
                    dispatch_value_rdy[k]          = 1'b1;
                end
            end
        end
    end

    // A mispredict stops retirement at the branch so nothing younger escapes the squash.
    always_comb begin
        logic [TAGW-1:0] ridx;
        ridx         = head_q;
        retire_valid = '0;
        retire_R_out = '0;
        retire_V_out = '0;
        n_ret        = '0;
        for (int k = 0; k < W; k++) begin
            ridx = head_q + TAGW'(k);
            if (ret_mask[k] && (!br_hit || (TAGW'(k) <= br_age))) begin
                retire_valid[k]          = 1'b1;
                retire_R_out[k*5 +: 5]   = entry_q[ridx].reg_idx;
                retire_V_out[k*32 +: 32] = entry_q[ridx].reg_val;
                n_ret                    = n_ret + CW'(1);
            end
        end
    end

    always_comb begin
        logic [TAGW-1:0] idx;
        logic [TAGW-1:0] age_i;
        idx     = '0;
        age_i   = '0;
        entry_d = entry_q;
        head_d  = head_q + TAGW'(n_ret);
        tail_d  = tail_q;
        count_d = count_q;

        for (int c = 0; c < C; c++) begin
            idx = CDB_rob_num[c*TAGW +: TAGW];
            if (cdb_valid[c] && entry_q[idx].valid) begin
                entry_d[idx].complete  = 1'b1;
                entry_d[idx].reg_val   = CDB_value[c*32 +: 32];
                entry_d[idx].exception = entry_q[idx].exception | cdb_exception[c];
            end
        end

        for (int k = 0; k < W; k++) begin
            if (retire_valid[k]) begin
                entry_d[head_q + TAGW'(k)] = '0;
            end
        end

        if (clear_all) begin
            for (int i = 0; i < SIZE; i++) begin
                entry_d[i] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (br_hit) begin
            for (int i = 0; i < SIZE; i++) begin
                age_i = TAGW'(i) - head_q;
                if (age_i > br_age) begin
                    entry_d[i] = '0;
                end
            end
            tail_d  = br_rob_tag + TAGW'(1);
            count_d = CW'(br_age) + CW'(1) - n_ret;
        end else begin
            for (int k = 0; k < W; k++) begin
                if (FW'(k) < accepted) begin
                    idx                    = tail_q + TAGW'(k);
                    entry_d[idx].valid     = 1'b1;
                    entry_d[idx].complete  = 1'b0;
                    entry_d[idx].exception = 1'b0;
                    entry_d[idx].reg_idx   = dest_reg_idx_in[k*5 +: 5];
                    entry_d[idx].reg_val   = '0;
                end
            end
            tail_d  = tail_q + TAGW'(accepted);
            count_d = count_q + CW'(accepted) - n_ret;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SIZE; i++) begin
                entry_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entry_q <= entry_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rob_nway.sv
// ============================================================================
//  tb_rob_nway : directed + randomized check of rob_nway (SIZE=8, W=3, C=3)
//                against a program-order queue model of the buffer
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rob_nway;

    logic        clk;
    logic        reset_n;
    logic [1:0]  dispatch_num;
    logic [14:0] dest_reg_idx_in;
    logic [8:0]  map_table_rob_num;
    logic [1:0]  dispatch_free;
    logic [8:0]  dispatch_tag;
    logic [95:0] dispatch_value_out;
    logic [2:0]  dispatch_value_rdy;
    logic [2:0]  cdb_valid;
    logic [8:0]  CDB_rob_num;
    logic [95:0] CDB_value;
    logic [2:0]  cdb_exception;
    logic        br_mispredict;
    logic [2:0]  br_rob_tag;
    logic        retire_en;
    logic [2:0]  retire_valid;
    logic [14:0] retire_R_out;
    logic [95:0] retire_V_out;
    logic        clear_all;
    logic [3:0]  rob_count;

    rob_nway #(.SIZE(8), .W(3), .C(3)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .dispatch_num       (dispatch_num),
        .dest_reg_idx_in    (dest_reg_idx_in),
        .map_table_rob_num  (map_table_rob_num),
        .dispatch_free      (dispatch_free),
        .dispatch_tag       (dispatch_tag),
        .dispatch_value_out (dispatch_value_out),
        .dispatch_value_rdy (dispatch_value_rdy),
        .cdb_valid          (cdb_valid),
        .CDB_rob_num        (CDB_rob_num),
        .CDB_value          (CDB_value),
        .cdb_exception      (cdb_exception),
        .br_mispredict      (br_mispredict),
        .br_rob_tag         (br_rob_tag),
        .retire_en          (retire_en),
        .retire_valid       (retire_valid),
        .retire_R_out       (retire_R_out),
        .retire_V_out       (retire_V_out),
        .clear_all          (clear_all),
        .rob_count          (rob_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [4:0]  r;
        logic [31:0] v;
        bit          comp;
        bit          exc;
    } ment_t;

    ment_t q[$];
    int    mhead;
    int    nvec;
    int    nmis;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nmis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        dispatch_num      = '0;
        dest_reg_idx_in   = '0;
        map_table_rob_num = '0;
        cdb_valid         = '0;
        CDB_rob_num       = '0;
        CDB_value         = '0;
        cdb_exception     = '0;
        br_mispredict     = 1'b0;
        br_rob_tag        = '0;
        retire_en         = 1'b0;
    endtask

    task automatic cdb(input int ch, input int tag, input int val, input bit exc);
        cdb_valid[ch]            = 1'b1;
        CDB_rob_num[ch*3 +: 3]   = 3'(tag);
        CDB_value[ch*32 +: 32]   = 32'(val);
        cdb_exception[ch]        = exc;
    endtask

    function automatic int age_of(input int t);
        return (t - mhead + 8) % 8;
    endfunction

    // Predict outputs from the queue, compare, clock once, then advance the queue.
    task automatic step();
        int          free, acc, n, brage, a, t;
        bit          brhit, e_clr;
        logic [8:0]  e_tag;
        logic [2:0]  e_rdy, e_rv;
        logic [95:0] e_fv, e_V;
        logic [14:0] e_R;
        ment_t       ne;
        #1;
        free  = (8 - q.size() < 3) ? 8 - q.size() : 3;
        acc   = (int'(dispatch_num) < free) ? int'(dispatch_num) : free;
        e_tag = '0;
        for (int k = 0; k < acc; k++) e_tag[k*3 +: 3] = 3'((mhead + q.size() + k) % 8);
        e_rdy = '0;
        e_fv  = '0;
        for (int k = 0; k < 3; k++) begin
            t = int'(map_table_rob_num[k*3 +: 3]);
            a = age_of(t);
            if (a < q.size() && q[a].comp) begin
                e_rdy[k]        = 1'b1;
                e_fv[k*32 +: 32] = q[a].v;
            end
            for (int c = 2; c >= 0; c--) begin
                if (cdb_valid[c] && int'(CDB_rob_num[c*3 +: 3]) == t) begin
                    e_rdy[k]        = 1'b1;
                    e_fv[k*32 +: 32] = CDB_value[c*32 +: 32];
                end
            end
        end
        brage = age_of(int'(br_rob_tag));
        brhit = br_mispredict && (brage < q.size());
        e_clr = retire_en && q.size() > 0 && q[0].comp && q[0].exc;
        n = 0;
        if (retire_en) while (n < 3 && n < q.size() && q[n].comp && !q[n].exc) n++;
        if (brhit && n > brage + 1) n = brage + 1;
        e_rv = '0;
        e_R  = '0;
        e_V  = '0;
        for (int k = 0; k < n; k++) begin
            e_rv[k]          = 1'b1;
            e_R[k*5 +: 5]    = q[k].r;
            e_V[k*32 +: 32]  = q[k].v;
        end
        chk("rob_count", rob_count, 128'(q.size()));
        chk("dispatch_free", dispatch_free, 128'(free));
        chk("dispatch_tag", dispatch_tag, e_tag);
        chk("fwd_rdy", dispatch_value_rdy, e_rdy);
        chk("fwd_value", dispatch_value_out, e_fv);
        chk("clear_all", clear_all, e_clr);
        chk("retire_valid", retire_valid, e_rv);
        chk("retire_R", retire_R_out, e_R);
        chk("retire_V", retire_V_out, e_V);

        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            a = age_of(int'(CDB_rob_num[c*3 +: 3]));
            if (cdb_valid[c] && a < q.size()) begin
                q[a].comp = 1'b1;
                q[a].v    = CDB_value[c*32 +: 32];
                q[a].exc  = q[a].exc | cdb_exception[c];
            end
        end
        if (e_clr) begin
            q.delete();
            mhead = 0;
        end else begin
            repeat (n) void'(q.pop_front());
            mhead = (mhead + n) % 8;
            if (brhit) begin
                while (q.size() > brage + 1 - n) void'(q.pop_back());
            end else begin
                for (int k = 0; k < acc; k++) begin
                    ne.tag  = (mhead + q.size()) % 8;
                    ne.r    = dest_reg_idx_in[k*5 +: 5];
                    ne.v    = '0;
                    ne.comp = 1'b0;
                    ne.exc  = 1'b0;
                    q.push_back(ne);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        #2;
        q.delete();
        mhead = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic set_random();
        int b;
        dispatch_num      = 2'($urandom_range(0, 3));
        dest_reg_idx_in   = 15'($urandom);
        map_table_rob_num = 9'($urandom);
        b = $urandom_range(0, 7);
        CDB_rob_num[2:0]  = 3'(b);
        CDB_rob_num[5:3]  = 3'(b + $urandom_range(1, 3));
        CDB_rob_num[8:6]  = 3'(b + $urandom_range(4, 7));
        cdb_valid         = 3'($urandom);
        CDB_value         = {$urandom, $urandom, $urandom};
        for (int c = 0; c < 3; c++) cdb_exception[c] = ($urandom_range(0, 15) == 0);
        br_mispredict     = ($urandom_range(0, 9) == 0);
        br_rob_tag        = 3'($urandom);
        retire_en         = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        nvec    = 0;
        nmis    = 0;
        mhead   = 0;
        q.delete();
        idle();
        reset_n = 1'b0;
        #1;
        chk("rst_free", dispatch_free, 128'd3);
        chk("rst_count", rob_count, 128'd0);
        chk("rst_tag", dispatch_tag, 128'd0);
        chk("rst_rdy", dispatch_value_rdy, 128'd0);
        chk("rst_retire", retire_valid, 128'd0);
        chk("rst_clear", clear_all, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // first dispatch R1..R3
        idle();
        dispatch_num    = 2'd3;
        dest_reg_idx_in = {5'd3, 5'd2, 5'd1};
        #1 chk("first_tags", dispatch_tag, {3'd2, 3'd1, 3'd0});
        step();
        chk("count_3", rob_count, 128'd3);
        chk("free_3", dispatch_free, 128'd3);

        // fill to full; last request only partly accepted, then none
        idle(); dispatch_num = 2'd3; dest_reg_idx_in = {5'd6, 5'd5, 5'd4}; step();
        idle(); dispatch_num = 2'd3; dest_reg_idx_in = {5'd9, 5'd8, 5'd7}; step();
        chk("full_count", rob_count, 128'd8);
        chk("full_free", dispatch_free, 128'd0);
        idle(); dispatch_num = 2'd3; dest_reg_idx_in = {5'd12, 5'd11, 5'd10}; step();
        chk("full_hold", rob_count, 128'd8);

        // complete 0..2 then retire all three
        idle(); cdb(0, 0, 15, 0); cdb(1, 1, 16, 0); cdb(2, 2, 17, 0); step();
        idle(); retire_en = 1'b1;
        #1 chk("ret3_mask", retire_valid, 128'b111);
        chk("ret3_R", retire_R_out, {5'd3, 5'd2, 5'd1});
        chk("ret3_V", retire_V_out, {32'd17, 32'd16, 32'd15});
        step();

        // out-of-order completion blocks retire until head completes
        idle(); retire_en = 1'b1; cdb(0, 4, 44, 0); step();
        idle(); retire_en = 1'b1;
        #1 chk("ret_blocked", retire_valid, 128'b000);
        cdb(0, 3, 33, 0);
        step();
        idle(); retire_en = 1'b1;
        #1 chk("ret_34", retire_valid, 128'b011);
        step();

        // wrap-around: drive head/tail to 6 with an empty buffer
        do_reset();
        idle(); dispatch_num = 2'd3; dest_reg_idx_in = {5'd3, 5'd2, 5'd1}; step();
        idle(); dispatch_num = 2'd3; dest_reg_idx_in = {5'd6, 5'd5, 5'd4}; step();
        idle(); cdb(0, 0, 1, 0); cdb(1, 1, 2, 0); cdb(2, 2, 3, 0); step();
        idle(); retire_en = 1'b1; cdb(0, 3, 4, 0); cdb(1, 4, 5, 0); cdb(2, 5, 6, 0); step();
        idle(); retire_en = 1'b1; step();
        chk("wrap_empty", rob_count, 128'd0);
        idle(); dispatch_num = 2'd3; dest_reg_idx_in = {5'd9, 5'd8, 5'd7};
        #1 chk("wrap_tags", dispatch_tag, {3'd0, 3'd7, 3'd6});
        step();
        idle(); map_table_rob_num = {3'd6, 3'd0, 3'd7}; cdb(0, 7, 42, 0);
        #1 chk("bypass_rdy", dispatch_value_rdy[0], 128'd1);
        chk("bypass_val", dispatch_value_out[31:0], 128'd42);
        step();

        // mispredict at tag 2 with a same-cycle write to a squashed entry
        do_reset();
        idle(); dispatch_num = 2'd3; dest_reg_idx_in = {5'd3, 5'd2, 5'd1}; step();
        idle(); dispatch_num = 2'd3; dest_reg_idx_in = {5'd6, 5'd5, 5'd4}; step();
        idle(); br_mispredict = 1'b1; br_rob_tag = 3'd2; cdb(0, 4, 99, 0); dispatch_num = 2'd3; step();
        chk("br_count", rob_count, 128'd3);
        idle(); dispatch_num = 2'd1; dest_reg_idx_in = 15'd20; map_table_rob_num = 9'd4;
        #1 chk("br_tail", dispatch_tag[2:0], 128'd3);
        chk("br_squash_rdy", dispatch_value_rdy[0], 128'd0);
        step();

        // exception on tag 1: tag 0 retires, then flush
        do_reset();
        idle(); dispatch_num = 2'd2; dest_reg_idx_in = {5'd0, 5'd6, 5'd5}; step();
        idle(); retire_en = 1'b1; cdb(0, 0, 5, 0); cdb(1, 1, 6, 1); step();
        idle(); retire_en = 1'b1;
        #1 chk("exc_ret0", retire_valid, 128'b001);
        chk("exc_noclr", clear_all, 128'd0);
        step();
        idle(); retire_en = 1'b1;
        #1 chk("exc_clear", clear_all, 128'd1);
        step();
        chk("exc_count", rob_count, 128'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            set_random();
            step();
        end

        // asynchronous reset in the middle of activity
        set_random();
        #2 reset_n = 1'b0;
        cdb_valid = '0;
        #1;
        chk("async_count", rob_count, 128'd0);
        chk("async_free", dispatch_free, 128'd3);
        chk("async_retire", retire_valid, 128'd0);
        chk("async_clear", clear_all, 128'd0);
        q.delete();
        mhead = 0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            set_random();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

`default_nettype wire
